// File: rtl/renkon_sched_pkg.sv
// Shared types for the renkon layer sequencer: FSM states, descriptor field
// codes and error codes.
package renkon_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] FLD_TOTAL_OUT   = 3'd0;
  localparam logic [2:0] FLD_TOTAL_IN    = 3'd1;
  localparam logic [2:0] FLD_IMG_SIZE    = 3'd2;
  localparam logic [2:0] FLD_FIL_SIZE    = 3'd3;
  localparam logic [2:0] FLD_POOL_SIZE   = 3'd4;
  localparam logic [2:0] FLD_INPUT_ADDR  = 3'd5;
  localparam logic [2:0] FLD_OUTPUT_ADDR = 3'd6;
  localparam logic [2:0] FLD_NET_ADDR    = 3'd7;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_DESC = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

endpackage

// File: rtl/renkon_sched_table.sv
// Layer descriptor register file: NLAYER rows of eight fields, one host
// write port and one combinational read port.
module renkon_sched_table
  import renkon_sched_pkg::*;
#(
  parameter int LWIDTH  = 10,
  parameter int IMGSIZE = 12,
  parameter int NETSIZE = 14,
  parameter int NLAYER  = 4,
  parameter int CWIDTH  = 16,
  parameter int LAYLOG  = $clog2(NLAYER)
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               we,
  input  logic [LAYLOG-1:0]  wr_layer,
  input  logic [2:0]         wr_field,
  input  logic [CWIDTH-1:0]  wr_data,
  input  logic [LAYLOG-1:0]  rd_layer,
  output logic [LWIDTH-1:0]  total_out,
  output logic [LWIDTH-1:0]  total_in,
  output logic [LWIDTH-1:0]  img_size,
  output logic [LWIDTH-1:0]  fil_size,
  output logic [LWIDTH-1:0]  pool_size,
  output logic [IMGSIZE-1:0] input_addr,
  output logic [IMGSIZE-1:0] output_addr,
  output logic [NETSIZE-1:0] net_addr
);

  logic [LWIDTH-1:0]  t_total_out   [NLAYER];
  logic [LWIDTH-1:0]  t_total_in    [NLAYER];
  logic [LWIDTH-1:0]  t_img_size    [NLAYER];
  logic [LWIDTH-1:0]  t_fil_size    [NLAYER];
  logic [LWIDTH-1:0]  t_pool_size   [NLAYER];
  logic [IMGSIZE-1:0] t_input_addr  [NLAYER];
  logic [IMGSIZE-1:0] t_output_addr [NLAYER];
  logic [NETSIZE-1:0] t_net_addr    [NLAYER];
  logic               unused_data;

  // Upper data bits beyond the widest field are dropped by design.
  assign unused_data = ^wr_data;

  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int i = 0; i < NLAYER; i++) begin
        t_total_out[i]   <= '0;
        t_total_in[i]    <= '0;
        t_img_size[i]    <= '0;
        t_fil_size[i]    <= '0;
        t_pool_size[i]   <= '0;
        t_input_addr[i]  <= '0;
        t_output_addr[i] <= '0;
        t_net_addr[i]    <= '0;
      end
    end else if (we) begin
      case (wr_field)
        FLD_TOTAL_OUT:   t_total_out[wr_layer]   <= wr_data[LWIDTH-1:0];
        FLD_TOTAL_IN:    t_total_in[wr_layer]    <= wr_data[LWIDTH-1:0];
        FLD_IMG_SIZE:    t_img_size[wr_layer]    <= wr_data[LWIDTH-1:0];
        FLD_FIL_SIZE:    t_fil_size[wr_layer]    <= wr_data[LWIDTH-1:0];
        FLD_POOL_SIZE:   t_pool_size[wr_layer]   <= wr_data[LWIDTH-1:0];
        FLD_INPUT_ADDR:  t_input_addr[wr_layer]  <= wr_data[IMGSIZE-1:0];
        FLD_OUTPUT_ADDR: t_output_addr[wr_layer] <= wr_data[IMGSIZE-1:0];
        FLD_NET_ADDR:    t_net_addr[wr_layer]    <= wr_data[NETSIZE-1:0];
        default: ;
      endcase
    end
  end

  assign total_out   = t_total_out[rd_layer];
  assign total_in    = t_total_in[rd_layer];
  assign img_size    = t_img_size[rd_layer];
  assign fil_size    = t_fil_size[rd_layer];
  assign pool_size   = t_pool_size[rd_layer];
  assign input_addr  = t_input_addr[rd_layer];
  assign output_addr = t_output_addr[rd_layer];
  assign net_addr    = t_net_addr[rd_layer];

endmodule

// File: rtl/renkon_sched.sv
// Layer sequencer in front of renkon: walks the descriptor table, issues one
// req per layer, waits for ack under a watchdog and reports status.
module renkon_sched
  import renkon_sched_pkg::*;
#(
  parameter int LWIDTH  = 10,
  parameter int IMGSIZE = 12,
  parameter int NETSIZE = 14,
  parameter int NLAYER  = 4,
  parameter int CWIDTH  = 16,
  parameter int TOWIDTH = 24,
  localparam int LAYLOG = $clog2(NLAYER)
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               cfg_we,
  input  logic [LAYLOG+2:0]  cfg_addr,
  input  logic [CWIDTH-1:0]  cfg_data,
  input  logic [LAYLOG:0]    n_layers,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [LAYLOG-1:0]  cur_layer,
  output logic [TOWIDTH-1:0] layer_cycles,
  output logic               req,
  output logic [LWIDTH-1:0]  total_out,
  output logic [LWIDTH-1:0]  total_in,
  output logic [LWIDTH-1:0]  img_size,
  output logic [LWIDTH-1:0]  fil_size,
  output logic [LWIDTH-1:0]  pool_size,
  output logic [IMGSIZE-1:0] input_addr,
  output logic [IMGSIZE-1:0] output_addr,
  output logic [NETSIZE-1:0] net_addr,
  input  logic               ack
);

  localparam logic [LAYLOG:0]    NLAY_MAX = (LAYLOG+1)'(NLAYER);
  localparam logic [TOWIDTH-1:0] WD_LAST  = {{(TOWIDTH-1){1'b1}}, 1'b0};

  state_t             state, state_nx;
  logic [LAYLOG:0]    n_lat, n_last, n_clamped;
  logic [TOWIDTH-1:0] wd;
  logic               tbl_we, desc_ok, last_layer, timeout;
  logic [LWIDTH-1:0]  t_total_out, t_total_in, t_img_size, t_fil_size, t_pool_size;
  logic [IMGSIZE-1:0] t_input_addr, t_output_addr;
  logic [NETSIZE-1:0] t_net_addr;

  assign tbl_we     = cfg_we && (state == S_IDLE);
  assign n_clamped  = (n_layers > NLAY_MAX) ? NLAY_MAX : n_layers;
  assign n_last     = n_lat - 1'b1;
  assign last_layer = ({1'b0, cur_layer} == n_last);
  // The watchdog reaches all-ones on the edge that ends the last allowed WAIT cycle.
  assign timeout    = (wd == WD_LAST);
  assign desc_ok    = (t_fil_size != '0) && (t_pool_size != '0) && (t_total_in != '0) &&
                      (t_total_out != '0) && (t_fil_size <= t_img_size);

  renkon_sched_table #(
    .LWIDTH (LWIDTH),
    .IMGSIZE(IMGSIZE),
    .NETSIZE(NETSIZE),
    .NLAYER (NLAYER),
    .CWIDTH (CWIDTH),
    .LAYLOG (LAYLOG)
  ) u_table (
    .clk        (clk),
    .xrst       (xrst),
    .we         (tbl_we),
    .wr_layer   (cfg_addr[LAYLOG+2:3]),
    .wr_field   (cfg_addr[2:0]),
    .wr_data    (cfg_data),
    .rd_layer   (cur_layer),
    .total_out  (t_total_out),
    .total_in   (t_total_in),
    .img_size   (t_img_size),
    .fil_size   (t_fil_size),
    .pool_size  (t_pool_size),
    .input_addr (t_input_addr),
    .output_addr(t_output_addr),
    .net_addr   (t_net_addr)
  );

  always_ff @(posedge clk) begin
    if (xrst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    req      = (state == S_ISSUE);
    done     = (state == S_DONE);
    if (abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nx = (n_layers == '0) ? S_DONE : S_CHECK;
        S_CHECK: state_nx = desc_ok ? S_ISSUE : S_ERR;
        S_ISSUE: state_nx = S_WAIT;
        S_WAIT: begin
          if (ack)          state_nx = S_NEXT;
          else if (timeout) state_nx = S_ERR;
        end
        S_NEXT:  state_nx = last_layer ? S_DONE : S_CHECK;
        S_DONE:  state_nx = S_IDLE;
        S_ERR:   state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Abort only leaves a trace when it cuts a layer short in WAIT.
  always_ff @(posedge clk) begin
    if (xrst) begin
      n_lat        <= '0;
      wd           <= '0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      cur_layer    <= '0;
      layer_cycles <= '0;
      total_out    <= '0;
      total_in     <= '0;
      img_size     <= '0;
      fil_size     <= '0;
      pool_size    <= '0;
      input_addr   <= '0;
      output_addr  <= '0;
      net_addr     <= '0;
    end else if (abort) begin
      if (state == S_WAIT) begin
        err      <= 1'b1;
        err_code <= ERR_ABORT;
      end
    end else begin
      case (state)
        S_IDLE: if (start) begin
          n_lat     <= n_clamped;
          err       <= 1'b0;
          err_code  <= ERR_NONE;
          cur_layer <= '0;
        end
        S_CHECK: if (desc_ok) begin
          total_out   <= t_total_out;
          total_in    <= t_total_in;
          img_size    <= t_img_size;
          fil_size    <= t_fil_size;
          pool_size   <= t_pool_size;
          input_addr  <= t_input_addr;
          output_addr <= t_output_addr;
          net_addr    <= t_net_addr;
        end else begin
          err      <= 1'b1;
          err_code <= ERR_BAD_DESC;
        end
        S_ISSUE: wd <= '0;
        S_WAIT: begin
          wd <= wd + 1'b1;
          if (ack) begin
            layer_cycles <= wd + 1'b1;
          end else if (timeout) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
          end
        end
        S_NEXT: if (!last_layer) cur_layer <= cur_layer + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_renkon_sched.sv
// Scoreboard bench for renkon_sched: the stimulus thread queues the expected
// req/done/error events and a monitor pops and compares them as they appear.
module tb_renkon_sched;

  logic        clk;
  logic        xrst;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic [2:0]  n_layers;
  logic        start, abort, ack;
  logic        busy, done, err, req;
  logic [1:0]  err_code;
  logic [1:0]  cur_layer;
  logic [7:0]  layer_cycles;
  logic [9:0]  total_out, total_in, img_size, fil_size, pool_size;
  logic [11:0] input_addr, output_addr;
  logic [13:0] net_addr;

  typedef struct {
    int               kind;
    int               layer;
    int               code;
    int               cyc;
    logic [7:0][31:0] f;
  } exp_t;

  localparam int K_REQ  = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  exp_t             exp_q[$];
  logic [7:0][31:0] tbl [4];
  int               tests_run;
  int               tests_failed;
  int               lat;
  int               cnt;
  int               dly [3];

  renkon_sched #(.TOWIDTH(8)) dut (
    .clk         (clk),
    .xrst        (xrst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .n_layers    (n_layers),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .cur_layer   (cur_layer),
    .layer_cycles(layer_cycles),
    .req         (req),
    .total_out   (total_out),
    .total_in    (total_in),
    .img_size    (img_size),
    .fil_size    (fil_size),
    .pool_size   (pool_size),
    .input_addr  (input_addr),
    .output_addr (output_addr),
    .net_addr    (net_addr),
    .ack         (ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic note_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: event missing or unexpected, required per scoreboard", name);
  endtask

  function automatic logic [31:0] field_mask(input int fld);
    if (fld <= 4)      return 32'h3FF;
    else if (fld <= 6) return 32'hFFF;
    else               return 32'h3FFF;
  endfunction

  task automatic write_field(input int layer, input int fld, input logic [15:0] data, input bit model);
    cfg_we   = 1'b1;
    cfg_addr = 5'(layer * 8 + fld);
    cfg_data = data;
    if (model) tbl[layer][fld] = {16'h0, data} & field_mask(fld);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic write_desc(input int layer, input int to, input int ti, input int img, input int fil,
                            input int pool, input int ia, input int oa, input int na);
    write_field(layer, 0, 16'(to), 1'b1);
    write_field(layer, 1, 16'(ti), 1'b1);
    write_field(layer, 2, 16'(img), 1'b1);
    write_field(layer, 3, 16'(fil), 1'b1);
    write_field(layer, 4, 16'(pool), 1'b1);
    write_field(layer, 5, 16'(ia), 1'b1);
    write_field(layer, 6, 16'(oa), 1'b1);
    write_field(layer, 7, 16'(na), 1'b1);
  endtask

  task automatic push_req(input int layer);
    exp_t e;
    e.kind = K_REQ; e.layer = layer; e.code = 0; e.cyc = 0; e.f = tbl[layer];
    exp_q.push_back(e);
  endtask

  task automatic push_end(input int kind, input int code, input int cyc);
    exp_t e;
    e.kind = kind; e.layer = 0; e.code = code; e.cyc = cyc; e.f = '0;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int n);
    n_layers = 3'(n);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_req(output int l);
    l = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (req) begin
        l = i;
        break;
      end
    end
    if (l == 0) note_fail("req_wait_timeout");
  endtask

  task automatic pulse_ack(input int d);
    repeat (d) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy && i < 50) begin
      @(negedge clk);
      i++;
    end
    checkOutput(name, 32'(busy), 0);
  endtask

  // Monitor: every req, done pulse and rising err must match the next queued event.
  initial begin : monitor
    exp_t e;
    logic prev_err;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!xrst) begin
        if (req) begin
          if (exp_q.size() == 0) note_fail("unexpected_req");
          else begin
            e = exp_q.pop_front();
            checkOutput("req_kind", K_REQ, e.kind);
            checkOutput("req_layer", 32'(cur_layer), e.layer);
            checkOutput("req_total_out", 32'(total_out), e.f[0]);
            checkOutput("req_total_in", 32'(total_in), e.f[1]);
            checkOutput("req_img_size", 32'(img_size), e.f[2]);
            checkOutput("req_fil_size", 32'(fil_size), e.f[3]);
            checkOutput("req_pool_size", 32'(pool_size), e.f[4]);
            checkOutput("req_input_addr", 32'(input_addr), e.f[5]);
            checkOutput("req_output_addr", 32'(output_addr), e.f[6]);
            checkOutput("req_net_addr", 32'(net_addr), e.f[7]);
          end
        end
        if (done) begin
          if (exp_q.size() == 0) note_fail("unexpected_done");
          else begin
            e = exp_q.pop_front();
            checkOutput("done_kind", K_DONE, e.kind);
            checkOutput("done_layer_cycles", 32'(layer_cycles), e.cyc);
            checkOutput("done_err", 32'(err), 0);
          end
        end
        if (err && !prev_err) begin
          if (exp_q.size() == 0) note_fail("unexpected_err");
          else begin
            e = exp_q.pop_front();
            checkOutput("err_kind", K_ERR, e.kind);
            checkOutput("err_code", 32'(err_code), e.code);
            checkOutput("err_layer_cycles", 32'(layer_cycles), e.cyc);
          end
        end
      end
      prev_err = err;
    end
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    xrst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    n_layers = '0; start = 1'b0; abort = 1'b0; ack = 1'b0;
    for (int i = 0; i < 4; i++) tbl[i] = '0;
    repeat (3) @(negedge clk);
    xrst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_req", 32'(req), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_err_code", 32'(err_code), 0);
    checkOutput("rst_cur_layer", 32'(cur_layer), 0);
    checkOutput("rst_layer_cycles", 32'(layer_cycles), 0);
    checkOutput("rst_total_out", 32'(total_out), 0);

    // Single layer, output address wider than the field.
    write_desc(0, 20, 1, 12, 5, 2, 0, 5000, 0);
    push_req(0); push_end(K_DONE, 0, 100);
    applyStimulus(1);
    checkOutput("t1_busy_after_start", 32'(busy), 1);
    checkOutput("t1_req_in_check", 32'(req), 0);
    wait_req(lat);
    checkOutput("t1_start_to_req", lat, 1);
    if (lat > 0) pulse_ack(100);
    wait_idle("t1_idle");
    checkOutput("t1_layer_cycles", 32'(layer_cycles), 100);
    checkOutput("t1_err", 32'(err), 0);

    // Three layers with distinct descriptors; fil_size == img_size on layer 1.
    write_desc(0, 7, 3, 10, 3, 1, 'h100, 'h200, 'h300);
    write_field(0, 0, 16'hFC09, 1'b1);
    write_desc(1, 15, 7, 8, 8, 2, 'h111, 'h222, 'h1333);
    write_desc(2, 1023, 512, 1023, 1, 3, 'hFFF, 'h0AB, 'h3FFF);
    push_req(0); push_req(1); push_req(2); push_end(K_DONE, 0, 3);
    dly[0] = 5; dly[1] = 1; dly[2] = 3;
    applyStimulus(3);
    for (int i = 0; i < 3; i++) begin
      wait_req(lat);
      checkOutput("t2_req_gap", lat, (i == 0) ? 1 : 2);
      if (lat > 0) pulse_ack(dly[i]);
    end
    wait_idle("t2_idle");
    checkOutput("t2_cur_layer", 32'(cur_layer), 2);

    // Layer 1 invalid (fil_size > img_size).
    write_field(1, 2, 16'd12, 1'b1);
    write_field(1, 3, 16'd13, 1'b1);
    push_req(0); push_end(K_ERR, 1, 4);
    applyStimulus(2);
    wait_req(lat);
    if (lat > 0) pulse_ack(4);
    wait_idle("t3_idle");
    checkOutput("t3_err", 32'(err), 1);
    checkOutput("t3_err_code", 32'(err_code), 1);
    checkOutput("t3_cur_layer", 32'(cur_layer), 1);
    repeat (5) @(negedge clk);

    // Watchdog timeout with an 8-bit counter.
    push_req(0); push_end(K_ERR, 2, 4);
    applyStimulus(1);
    wait_req(lat);
    cnt = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (err) begin
        cnt = i;
        break;
      end
    end
    checkOutput("t4_req_to_err", cnt, 256);
    wait_idle("t4_idle");
    checkOutput("t4_err_code", 32'(err_code), 2);
    checkOutput("t4_layer_cycles", 32'(layer_cycles), 4);

    // Abort together with ack in WAIT, then a clean rerun.
    push_req(0); push_end(K_ERR, 3, 4);
    applyStimulus(1);
    wait_req(lat);
    if (lat > 0) begin
      repeat (10) @(negedge clk);
      ack = 1'b1; abort = 1'b1;
      @(negedge clk);
      ack = 1'b0; abort = 1'b0;
    end
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_err", 32'(err), 1);
    checkOutput("t5_err_code", 32'(err_code), 3);
    checkOutput("t5_layer_cycles", 32'(layer_cycles), 4);
    push_req(0); push_end(K_DONE, 0, 6);
    applyStimulus(1);
    checkOutput("t5_err_cleared", 32'(err), 0);
    wait_req(lat);
    if (lat > 0) pulse_ack(6);
    wait_idle("t5_idle");

    // Zero layers, then table writes and start while busy are ignored.
    push_end(K_DONE, 0, 6);
    applyStimulus(0);
    lat = done ? 1 : 0;
    for (int i = 2; i <= 5 && lat == 0; i++) begin
      @(negedge clk);
      if (done) lat = i;
    end
    checkOutput("t6_done_within_2", 32'(lat >= 1 && lat <= 2), 1);
    wait_idle("t6_idle_n0");
    push_req(0); push_end(K_DONE, 0, 3);
    applyStimulus(1);
    wait_req(lat);
    if (lat > 0) begin
      start = 1'b1;
      write_field(0, 0, 16'd999, 1'b0);
      repeat (2) @(negedge clk);
      ack = 1'b1; start = 1'b0;
      @(negedge clk);
      ack = 1'b0;
    end
    start = 1'b0;
    wait_idle("t6_idle_busy_write");
    repeat (3) @(negedge clk);
    push_req(0); push_end(K_DONE, 0, 2);
    applyStimulus(1);
    wait_req(lat);
    if (lat > 0) pulse_ack(2);
    wait_idle("t6_idle_rerun");

    // n_layers above the table depth is clamped to four layers.
    write_desc(1, 15, 7, 12, 3, 2, 'h111, 'h222, 'h1333);
    write_desc(3, 100, 50, 20, 20, 4, 'h010, 'h020, 'h030);
    push_req(0); push_req(1); push_req(2); push_req(3); push_end(K_DONE, 0, 2);
    applyStimulus(7);
    for (int i = 0; i < 4; i++) begin
      wait_req(lat);
      if (lat > 0) pulse_ack(2);
    end
    wait_idle("t7_idle");
    checkOutput("t7_cur_layer", 32'(cur_layer), 3);

    // Reset mid-run clears outputs and the table.
    push_req(0);
    applyStimulus(1);
    wait_req(lat);
    repeat (5) @(negedge clk);
    xrst = 1'b1;
    @(negedge clk);
    checkOutput("t8_busy", 32'(busy), 0);
    checkOutput("t8_req", 32'(req), 0);
    checkOutput("t8_total_out", 32'(total_out), 0);
    checkOutput("t8_net_addr", 32'(net_addr), 0);
    checkOutput("t8_layer_cycles", 32'(layer_cycles), 0);
    xrst = 1'b0;
    for (int i = 0; i < 4; i++) tbl[i] = '0;
    @(negedge clk);
    push_end(K_ERR, 1, 0);
    applyStimulus(1);
    wait_idle("t8_idle");
    checkOutput("t8_err_code", 32'(err_code), 1);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
